// File: rtl/ycfsm.sv
// rtl/ycfsm.sv - Morphle Logic yellow-cell FSM: latches dual-rail in/match tokens and emits their compare result.
// Optional illegal-code detection (sticky err_o) is enabled by defining YCFSM_ILLEGAL_DETECT_EN.
module ycfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] in_i,
    input  logic [1:0] match_i,
`ifdef YCFSM_ILLEGAL_DETECT_EN
    output logic       err_o,
`endif
    output logic [1:0] out_o
);

    localparam logic [1:0] V_EMPTY = 2'b00;
    localparam logic [1:0] V_0     = 2'b01;
    localparam logic [1:0] V_1     = 2'b10;
    localparam logic [1:0] V_ILL   = 2'b11;

    logic [1:0] lin_q, lin_d;
    logic [1:0] lmatch_q, lmatch_d;
    logic       inval, matchval, linval, lmatchval, clear;
    logic       in_ok, match_ok;

    assign inval     = in_i[0] | in_i[1];
    assign matchval  = match_i[0] | match_i[1];
    assign linval    = lin_q[0] | lin_q[1];
    assign lmatchval = lmatch_q[0] | lmatch_q[1];
    assign clear     = linval & lmatchval & ~inval & ~matchval;

`ifdef YCFSM_ILLEGAL_DETECT_EN
    logic err_q, err_d;

    // Illegal codes are never latched, so the channel stays empty until a legal token arrives.
    assign in_ok    = (in_i != V_ILL);
    assign match_ok = (match_i != V_ILL);
    assign err_d    = err_q | ~in_ok | ~match_ok;
    assign err_o    = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign in_ok    = 1'b1;
    assign match_ok = 1'b1;
`endif

    always_comb begin
        lin_d    = lin_q;
        lmatch_d = lmatch_q;
        if (clear) begin
            lin_d    = V_EMPTY;
            lmatch_d = V_EMPTY;
        end else begin
            if (!linval && inval && in_ok) begin
                lin_d = in_i;
            end
            if (!lmatchval && matchval && match_ok) begin
                lmatch_d = match_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lin_q    <= V_EMPTY;
            lmatch_q <= V_EMPTY;
        end else begin
            lin_q    <= lin_d;
            lmatch_q <= lmatch_d;
        end
    end

    always_comb begin
        out_o = V_EMPTY;
        if (linval && lmatchval) begin
            out_o = (lin_q == lmatch_q) ? V_1 : V_0;
        end
    end

endmodule

// File: tb/tb_ycfsm.sv
// tb/tb_ycfsm.sv - directed self-checking bench for ycfsm; covers the YCFSM_ILLEGAL_DETECT_EN build when defined.
module tb_ycfsm;

    logic       clk;
    logic       reset;
    logic [1:0] in_i;
    logic [1:0] match_i;
    logic [1:0] out_o;
`ifdef YCFSM_ILLEGAL_DETECT_EN
    logic       err_o;
`endif

    int n_pass;
    int n_total;

    ycfsm dut (
        .clk     (clk),
        .reset   (reset),
        .in_i    (in_i),
        .match_i (match_i),
`ifdef YCFSM_ILLEGAL_DETECT_EN
        .err_o   (err_o),
`endif
        .out_o   (out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        in_i    = 2'b00;
        match_i = 2'b00;
        #3;
        chk("reset_during", out_o, 2'b00);
        step();
        reset = 1'b0;
        step();
        chk("reset_after", out_o, 2'b00);

        // in=V1 first, match=V1 two cycles later
        in_i = 2'b10;
        step();
        chk("in_only_1", out_o, 2'b00);
        step();
        chk("in_only_2", out_o, 2'b00);
        match_i = 2'b10;
        step();
        chk("both_v1", out_o, 2'b10);
        match_i = 2'b00;
        step();
        chk("match_drop_hold", out_o, 2'b10);
        step();
        chk("match_drop_hold2", out_o, 2'b10);
        in_i = 2'b00;
        step();
        chk("clear_seq", out_o, 2'b00);

        // same-edge arrival, unequal tokens
        in_i    = 2'b01;
        match_i = 2'b10;
        step();
        chk("same_edge_ne", out_o, 2'b01);
        in_i    = 2'b00;
        match_i = 2'b00;
        step();
        chk("same_edge_clear", out_o, 2'b00);

        // held lin value ignores later change on in
        in_i = 2'b10;
        step();
        chk("hold_a", out_o, 2'b00);
        in_i = 2'b01;
        step();
        chk("hold_b", out_o, 2'b00);
        match_i = 2'b10;
        step();
        chk("hold_used", out_o, 2'b10);

        // async reset mid-operation, then recapture of present tokens
        #2;
        reset   = 1'b1;
        in_i    = 2'b10;
        match_i = 2'b10;
        #1;
        chk("async_reset", out_o, 2'b00);
        step();
        chk("reset_held", out_o, 2'b00);
        reset = 1'b0;
        step();
        chk("recapture", out_o, 2'b10);
        in_i    = 2'b00;
        match_i = 2'b00;
        step();
        chk("recapture_clear", out_o, 2'b00);

        // input empties before partner arrives; latched value kept, no clear
        in_i = 2'b01;
        step();
        in_i = 2'b00;
        step();
        chk("early_drop", out_o, 2'b00);
        match_i = 2'b01;
        step();
        chk("early_drop_cmp", out_o, 2'b10);
        step();
        chk("no_clear_match_up", out_o, 2'b10);
        match_i = 2'b00;
        step();
        chk("late_clear", out_o, 2'b00);

`ifdef YCFSM_ILLEGAL_DETECT_EN
        chk("err_clean", {1'b0, err_o}, 2'b00);
        in_i = 2'b11;
        step();
        chk("err_set", {1'b0, err_o}, 2'b01);
        match_i = 2'b01;
        step();
        chk("ill_not_latched", out_o, 2'b00);
        in_i = 2'b01;
        step();
        chk("legal_after_ill", out_o, 2'b10);
        in_i    = 2'b00;
        match_i = 2'b00;
        step();
        chk("err_sticky", {1'b0, err_o}, 2'b01);
        chk("ill_clear", out_o, 2'b00);
        reset = 1'b1;
        #1;
        chk("err_reset", {1'b0, err_o}, 2'b00);
        step();
        reset = 1'b0;
        step();
`else
        // 2'b11 is an ordinary non-empty code compared with full equality
        in_i    = 2'b11;
        match_i = 2'b01;
        step();
        chk("code11_ne", out_o, 2'b01);
        in_i    = 2'b00;
        match_i = 2'b00;
        step();
        chk("code11_clear", out_o, 2'b00);
        in_i    = 2'b11;
        match_i = 2'b11;
        step();
        chk("code11_eq", out_o, 2'b10);
        in_i    = 2'b00;
        match_i = 2'b00;
        step();
`endif
        chk("final_empty", out_o, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
